// File: rtl/instr_fetch_unit.sv
// Fetch stage of the 8-bit CPU: program counter, IF/ID holding register with a
// valid/ready handshake to decode, local unconditional jumps, redirects and end-of-program halt.
module instr_fetch_unit #(
  parameter int ADDR_W     = 8,
  parameter int IMEM_DEPTH = 32,
  parameter int RESET_PC   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] Read_Address,
  input  logic [7:0]        Instruction_In,
  output logic [7:0]        Instr_Out,
  output logic [ADDR_W-1:0] PC_Out,
  output logic              Instr_Valid,
  input  logic              Decode_Ready,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] Redirect_Addr,
  output logic              Halted,
  output logic [15:0]       Fetch_Count
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HOLD, S_HALT} state_t;

  // One extra bit so that IMEM_DEPTH == 2**ADDR_W is representable and never halts.
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_instr;
  logic [ADDR_W-1:0] r_pc_out;
  logic              r_valid;
  logic              r_halted;
  logic [15:0]       r_count;

  logic              w_jump;
  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_next_oob;
  logic              w_redir_oob;
  logic              w_capture;

  // A jump keeps the upper bits of the sequential PC and replaces the low six bits.
  assign w_jump      = (Instruction_In[7:6] == 2'b11);
  assign w_seq       = r_pc + ADDR_W'(1);
  assign w_next_pc   = w_jump ? {w_seq[ADDR_W-1:6], Instruction_In[5:0]} : w_seq;
  assign w_next_oob  = ({1'b0, w_next_pc} >= DEPTH_L);
  assign w_redir_oob = ({1'b0, Redirect_Addr} >= DEPTH_L);
  assign w_capture   = ((r_state == S_RUN) || (r_state == S_HOLD)) &&
                       (!r_valid || Decode_Ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_BOOT;
      r_pc     <= PC_RST;
      r_instr  <= '0;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_count  <= '0;
    end else if (r_state == S_BOOT) begin
      r_state <= S_RUN;
    end else if (Redirect) begin
      r_valid <= 1'b0;
      if (w_redir_oob) begin
        r_state  <= S_HALT;
        r_halted <= 1'b1;
      end else begin
        r_pc     <= Redirect_Addr;
        r_halted <= 1'b0;
        r_state  <= S_RUN;
      end
    end else begin
      case (r_state)
        S_RUN, S_HOLD: begin
          if (w_capture) begin
            r_instr  <= Instruction_In;
            r_pc_out <= r_pc;
            r_valid  <= 1'b1;
            if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
            if (w_next_oob) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= S_RUN;
            end
          end else begin
            r_state <= S_HOLD;
          end
        end
        S_HALT: begin
          if (Decode_Ready) r_valid <= 1'b0;
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign Read_Address = r_pc;
  assign Instr_Out    = r_instr;
  assign PC_Out       = r_pc_out;
  assign Instr_Valid  = r_valid;
  assign Halted       = r_halted;
  assign Fetch_Count  = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus queues expected {PC, instruction}
// pairs, a negedge monitor pops one per decode handshake.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  Read_Address;
  logic [7:0]  Instruction_In;
  logic [7:0]  Instr_Out;
  logic [7:0]  PC_Out;
  logic        Instr_Valid;
  logic        Decode_Ready;
  logic        Redirect;
  logic [7:0]  Redirect_Addr;
  logic        Halted;
  logic [15:0] Fetch_Count;

  logic [7:0]  mem [256];
  logic [15:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign Instruction_In = mem[Read_Address];

  instr_fetch_unit #(.ADDR_W(8), .IMEM_DEPTH(23), .RESET_PC(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Read_Address  (Read_Address),
    .Instruction_In(Instruction_In),
    .Instr_Out     (Instr_Out),
    .PC_Out        (PC_Out),
    .Instr_Valid   (Instr_Valid),
    .Decode_Ready  (Decode_Ready),
    .Redirect      (Redirect),
    .Redirect_Addr (Redirect_Addr),
    .Halted        (Halted),
    .Fetch_Count   (Fetch_Count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] pc);
    exp_q.push_back({pc, mem[pc]});
  endtask

  task automatic wait_ra(input logic [7:0] a);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (Read_Address == a) return;
    end
    chk("wait_read_address_timeout", 0, 1);
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (Halted) return;
    end
    chk("wait_halt_timeout", 0, 1);
  endtask

  // Monitor: one pop per accepted instruction.
  always @(negedge clk) begin
    if (rst_n && Instr_Valid && Decode_Ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_handshake_pc", int'(PC_Out), -1);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("sb_instr", int'(Instr_Out), int'(e[7:0]));
        chk("sb_pc", int'(PC_Out), int'(e[15:8]));
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = (i < 23) ? 8'(8'h10 + i) : 8'h00;
    mem[0] = 8'h45; mem[1] = 8'h84; mem[2] = 8'h58; mem[3] = 8'h27;
    mem[10] = 8'h44; mem[19] = 8'hC1;

    rst_n = 1'b0; Decode_Ready = 1'b1; Redirect = 1'b0; Redirect_Addr = 8'h00;
    repeat (2) @(posedge clk); #1;
    chk("rst_valid", Instr_Valid, 0);
    chk("rst_instr", Instr_Out, 0);
    chk("rst_pc_out", PC_Out, 0);
    chk("rst_halted", Halted, 0);
    chk("rst_count", Fetch_Count, 0);
    chk("rst_read_addr", Read_Address, 0);

    // T1 + T3: boot cycle, three captures, then a 4-cycle stall on 0x58
    push(0); push(1); push(2);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("boot_no_capture", Instr_Valid, 0);
    @(posedge clk); #1;
    chk("first_capture_valid", Instr_Valid, 1);
    repeat (2) @(posedge clk); #1;
    chk("t1_instr", Instr_Out, 8'h58);
    chk("t1_pc_out", PC_Out, 2);
    chk("t1_count", Fetch_Count, 3);
    Decode_Ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("hold_instr", Instr_Out, 8'h58);
      chk("hold_pc_out", PC_Out, 2);
      chk("hold_read_addr", Read_Address, 3);
      chk("hold_count", Fetch_Count, 3);
    end
    for (int k = 3; k <= 19; k++) push(8'(k));
    for (int k = 1; k <= 18; k++) push(8'(k));
    push(10); push(20); push(21); push(22);
    Decode_Ready = 1'b1;
    @(posedge clk); #1;
    chk("resume_instr", Instr_Out, 8'h27);
    chk("resume_pc_out", PC_Out, 3);

    // T2: jump at 19 back to 1 without a bubble
    wait_ra(19);
    @(posedge clk); #1;
    chk("jump_instr", Instr_Out, 8'hC1);
    chk("jump_pc_out", PC_Out, 19);
    @(posedge clk); #1;
    chk("jump_target_instr", Instr_Out, 8'h84);
    chk("jump_target_pc_out", PC_Out, 1);

    // T4: redirect on the same edge as the second jump capture
    wait_ra(19);
    Redirect = 1'b1; Redirect_Addr = 8'd10;
    @(posedge clk); #1;
    Redirect = 1'b0;
    chk("redir_flush_valid", Instr_Valid, 0);
    chk("redir_read_addr", Read_Address, 10);
    @(posedge clk); #1;
    chk("redir_instr", Instr_Out, 8'h44);
    chk("redir_pc_out", PC_Out, 10);

    // T5: run 20..22, halt at end of program
    Redirect = 1'b1; Redirect_Addr = 8'd20;
    @(posedge clk); #1;
    Redirect = 1'b0;
    chk("redir20_read_addr", Read_Address, 20);
    wait_halt();
    Decode_Ready = 1'b0;
    chk("halt_valid", Instr_Valid, 1);
    chk("halt_instr", Instr_Out, 8'h26);
    chk("halt_pc_out", PC_Out, 22);
    chk("halt_read_addr", Read_Address, 22);
    repeat (2) begin
      @(posedge clk); #1;
      chk("halt_hold_valid", Instr_Valid, 1);
      chk("halt_hold_halted", Halted, 1);
      chk("halt_hold_read_addr", Read_Address, 22);
    end
    Decode_Ready = 1'b1;
    @(posedge clk); #1;
    chk("halt_drain_valid", Instr_Valid, 0);
    chk("halt_drain_halted", Halted, 1);
    push(0);
    Redirect = 1'b1; Redirect_Addr = 8'd0;
    @(posedge clk); #1;
    Redirect = 1'b0;
    chk("unhalt_halted", Halted, 0);
    chk("unhalt_valid", Instr_Valid, 0);
    chk("unhalt_read_addr", Read_Address, 0);
    @(posedge clk); #1;
    chk("unhalt_capture_valid", Instr_Valid, 1);
    chk("unhalt_next_pc", Read_Address, 1);

    // Redirect beyond program end halts without moving the PC
    Redirect = 1'b1; Redirect_Addr = 8'd30;
    @(posedge clk); #1;
    chk("oob_redir_halted", Halted, 1);
    chk("oob_redir_valid", Instr_Valid, 0);
    chk("oob_redir_read_addr", Read_Address, 1);

    // T6: async reset during HOLD
    Redirect_Addr = 8'd0; Decode_Ready = 1'b0;
    @(posedge clk); #1;
    Redirect = 1'b0;
    chk("t6_unhalt", Halted, 0);
    @(posedge clk); #1;
    chk("t6_capture_valid", Instr_Valid, 1);
    chk("t6_capture_instr", Instr_Out, 8'h45);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", Instr_Valid, 0);
    chk("t6_rst_instr", Instr_Out, 0);
    chk("t6_rst_pc_out", PC_Out, 0);
    chk("t6_rst_halted", Halted, 0);
    chk("t6_rst_count", Fetch_Count, 0);
    chk("t6_rst_read_addr", Read_Address, 0);
    push(0);
    Decode_Ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_boot_no_capture", Instr_Valid, 0);
    @(posedge clk); #1;
    chk("t6_first_valid", Instr_Valid, 1);
    chk("t6_first_count", Fetch_Count, 1);
    @(posedge clk); #1;
    Decode_Ready = 1'b0;
    @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
